hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RISC-V core. It produces E-stage operand forwarding selects, the load-use bubble, and the taken-branch/jump flush of D and E. It also sequences multi-cycle execute operations (M-extension divider) through a start/done handshake with a timeout. Sits beside the F/D/E/M/W pipeline registers and drives their stall and flush inputs; 16-bit saturating counters expose stall and flush activity.

---
 rtl/hazard_if.sv | 28 ++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Bundle of pipeline-side signals between the F/D/E/M/W datapath and hazard_ctrl.
// master = pipeline side, slave = hazard controller.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             regwriteM, regwriteW, resultsrcE, pcsrcE;
    logic             mc_startE, mc_done;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE;
    logic             flushD, flushE, flushM;
    logic             mc_go, mc_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output regwriteM, regwriteW, resultsrcE, pcsrcE, mc_startE, mc_done,
        input  forwardAE, forwardBE, stallF, stallD, stallE,
        input  flushD, flushE, flushM, mc_go, mc_error, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  regwriteM, regwriteW, resultsrcE, pcsrcE, mc_startE, mc_done,
        output forwardAE, forwardBE, stallF, stallD, stallE,
        output flushD, flushE, flushM, mc_go, mc_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: E-stage forwarding, load-use bubble, branch flush and
// multi-cycle execute sequencing with timeout; saturating stall/flush counters.
//
// state   | meaning
// RUN     | normal issue; resolves branch flush, mc entry, load-use bubble
// MC_WAIT | pipeline frozen waiting for mc_done or timeout
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input logic      clk,
    input logic      rst,
    hazard_if.slave  hz
);
    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0]    T_LAST  = TW'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t           state, state_n;
    logic [TW-1:0]    tcnt;
    logic             err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [1:0] fwd_a, fwd_b;
    logic       lu, timeout_hit;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, go;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.regwriteM && hz.rdM != 5'd0 && hz.rdM == rs)
            return 2'b10;
        else if (hz.regwriteW && hz.rdW != 5'd0 && hz.rdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lu = hz.resultsrcE && hz.rdE != 5'd0 &&
                (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);

    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        go          = 1'b0;
        // Everything is held quiet while reset is asserted.
        if (rst) begin
            fwd_a = fwd_sel(hz.rs1E);
            fwd_b = fwd_sel(hz.rs2E);
            case (state)
                RUN: begin
                    if (hz.pcsrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (hz.mc_startE) begin
                        go      = 1'b1;
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        state_n = MC_WAIT;
                    end else if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (hz.mc_done) begin
                        state_n = RUN;
                    end else if (tcnt == T_LAST) begin
                        timeout_hit = 1'b1;
                        state_n     = RUN;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            tcnt      <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == RUN && state_n == MC_WAIT)
                tcnt <= TW'(1);
            else if (state == MC_WAIT && state_n == MC_WAIT)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (timeout_hit)
                err <= 1'b1;
            if (stall_f && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((flush_d || flush_e) && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.forwardAE = fwd_a;
    assign hz.forwardBE = fwd_b;
    assign hz.stallF    = stall_f;
    assign hz.stallD    = stall_d;
    assign hz.stallE    = stall_e;
    assign hz.flushD    = flush_d;
    assign hz.flushE    = flush_e;
    assign hz.flushM    = flush_m;
    assign hz.mc_go     = go;
    assign hz.mc_error  = err;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
endmodule
